serial_result_shifter: RTL and testbench

- Output-side counterpart of the input shift register in the compressor test harnesses.
- Captures the compressor's parallel dst bits (packed into one vector) in a single cycle.
- Shifts the captured word out one bit per enabled cycle, LSB (dst0) first, so a pin-limited test wrapper can observe all result columns serially.
- Sits between the compressor instance and the wrapper's single serial output pin.

---
 rtl/serial_shifter_pkg.sv | 18 +
 rtl/serial_result_shifter.sv | 94 +++++++++
 tb/tb_serial_result_shifter.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_shifter_pkg.sv
// Shared definitions for the serial shift harness blocks (input and output side).
package serial_shifter_pkg;

    // Two-state control: waiting for a word, or presenting its bits serially.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } shifter_state_e;

    // Bit-counter width for a given word width; never less than one bit.
    function automatic int calc_cnt_w(input int width);
        if (width <= 2) begin
            return 1;
        end
        return $clog2(width);
    endfunction

endpackage

// File: rtl/serial_result_shifter.sv
// Captures a parallel result vector and shifts it out LSB first, one bit per
// enabled cycle. Supports back-to-back words with no bubble and holds all
// outputs while shift_en is low.
module serial_result_shifter
    import serial_shifter_pkg::*;
#(
    parameter int WIDTH = 34
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             shift_en,
    output logic             ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             last,
    output logic             done
);

    localparam int                CNT_W    = calc_cnt_w(WIDTH);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);

    shifter_state_e    state_q;
    shifter_state_e    state_d;
    logic [WIDTH-1:0]  sreg_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              done_q;

    logic              is_last;
    logic              finishing;
    logic              accept;

    // Control state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and outputs; ready may open in the final-bit cycle
    // so a new word can follow without a gap.
    always_comb begin
        state_d    = state_q;
        is_last    = 1'b0;
        finishing  = 1'b0;
        ready      = 1'b0;
        accept     = 1'b0;
        dout       = 1'b0;
        dout_valid = 1'b0;
        last       = 1'b0;

        is_last    = (state_q == SHIFT) && (cnt_q == LAST_CNT);
        finishing  = is_last && shift_en;
        ready      = (state_q == IDLE) || finishing;
        accept     = load && ready;

        dout       = (state_q == SHIFT) && sreg_q[0];
        dout_valid = (state_q == SHIFT);
        last       = is_last;

        if (accept) begin
            state_d = SHIFT;
        end else if (finishing) begin
            state_d = IDLE;
        end
    end

    // Shift register, bit counter and registered completion pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            sreg_q <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= finishing;
            if (accept) begin
                sreg_q <= din;
                cnt_q  <= '0;
            end else if (finishing) begin
                sreg_q <= '0;
                cnt_q  <= '0;
            end else if ((state_q == SHIFT) && shift_en) begin
                sreg_q <= {1'b0, sreg_q[WIDTH-1:1]};
                cnt_q  <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign done = done_q;

endmodule

// File: tb/tb_serial_result_shifter.sv
// Scoreboard bench for serial_result_shifter: the stimulus queues the expected
// serial bits per presented cycle, a monitor pops and compares on dout_valid.
module tb_serial_result_shifter;

    localparam int W = 34;

    logic         clk;
    logic         rst;
    logic         load;
    logic [W-1:0] din;
    logic         shift_en;
    logic         ready;
    logic         dout;
    logic         dout_valid;
    logic         last;
    logic         done;

    int n_cmp;
    int n_fail;
    int done_cnt;

    logic [1:0] exp_q[$];

    serial_result_shifter #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .din        (din),
        .shift_en   (shift_en),
        .ready      (ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .last       (last),
        .done       (done)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Absolute time bound on the whole run.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "timeout");
    end

    function automatic void check(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, required %b (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void check_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Monitor: every cycle with dout_valid must match the next queued bit.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cnt++;
        end
        if (dout_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL extra_bit: got dout=%b last=%b, required no valid output", dout, last);
            end else begin
                logic [1:0] e;
                e = exp_q.pop_front();
                check("dout", dout, e[1]);
                check("last", last, e[0]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Queue one word's presented bits; bit hold_at is repeated hold_n extra times.
    task automatic push_word(input logic [W-1:0] d, input int hold_at, input int hold_n);
        for (int k = 0; k < W; k++) begin
            exp_q.push_back({d[k], (k == W - 1)});
            if (k == hold_at) begin
                for (int h = 0; h < hold_n; h++) begin
                    exp_q.push_back({d[k], (k == W - 1)});
                end
            end
        end
    endtask

    // One full word from IDLE, optional stall at hold_at, optional refused load at ign_at.
    task automatic run_word(input logic [W-1:0] d, input int hold_at, input int hold_n,
                            input int ign_at);
        int d0;
        d0       = done_cnt;
        din      = d;
        load     = 1'b1;
        shift_en = 1'b1;
        @(negedge clk);
        check("idle_ready", ready, 1'b1);
        push_word(d, hold_at, hold_n);
        step();
        for (int k = 0; k < W; k++) begin
            load = (k == ign_at);
            din  = (k == ign_at) ? W'(1) : '0;
            if (k == hold_at) begin
                shift_en = 1'b0;
                for (int h = 0; h < hold_n; h++) begin
                    @(negedge clk);
                    check("hold_ready", ready, 1'b0);
                    check("hold_done", done, 1'b0);
                    check("hold_valid", dout_valid, 1'b1);
                    step();
                end
                shift_en = 1'b1;
            end
            @(negedge clk);
            check("word_done_early", done, 1'b0);
            check("word_ready", ready, (k == W - 1));
            step();
        end
        load = 1'b0;
        din  = '0;
        @(negedge clk);
        check("word_done", done, 1'b1);
        check("word_end_ready", ready, 1'b1);
        check("word_end_valid", dout_valid, 1'b0);
        step();
        @(negedge clk);
        check("word_done_pulse", done, 1'b0);
        check_int("word_done_count", done_cnt - d0, 1);
        step();
    endtask

    initial begin
        int d0;
        n_cmp    = 0;
        n_fail   = 0;
        done_cnt = 0;
        rst      = 1'b1;
        load     = 1'b1;
        din      = '1;
        shift_en = 1'b1;

        // Reset held two cycles with load asserted and din all ones.
        step();
        @(negedge clk);
        check("rst_ready", ready, 1'b1);
        check("rst_valid", dout_valid, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_dout", dout, 1'b0);
        step();
        rst  = 1'b0;
        load = 1'b0;
        @(negedge clk);
        check("post_rst_ready", ready, 1'b1);
        check("post_rst_valid", dout_valid, 1'b0);
        check("post_rst_done", done, 1'b0);
        check("post_rst_dout", dout, 1'b0);
        step();

        // Basic word: 0,1,0,1,1,0,1,0 x4 then 0,1.
        run_word(34'h2_5A5A_5A5A, -1, 0, -1);

        // Backpressure: three stalled cycles on bit 5.
        run_word(34'h2_5A5A_5A5A, 5, 3, -1);

        // Refused load mid-word, then stays idle.
        run_word(34'h0, -1, 0, 10);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_valid", dout_valid, 1'b0);
            step();
        end

        // Back-to-back: all-zero word, then all-ones loaded on its last bit.
        d0       = done_cnt;
        din      = '0;
        load     = 1'b1;
        shift_en = 1'b1;
        push_word(34'h0, -1, 0);
        step();
        load = 1'b0;
        for (int k = 0; k < W - 1; k++) begin
            step();
        end
        load = 1'b1;
        din  = 34'h3_FFFF_FFFF;
        @(negedge clk);
        check("b2b_ready", ready, 1'b1);
        push_word(34'h3_FFFF_FFFF, -1, 0);
        step();
        load = 1'b0;
        din  = '0;
        for (int k = 0; k < W; k++) begin
            @(negedge clk);
            check("b2b_done", done, (k == 0));
            check("b2b_valid", dout_valid, 1'b1);
            step();
        end
        @(negedge clk);
        check("b2b_final_done", done, 1'b1);
        check("b2b_final_valid", dout_valid, 1'b0);
        step();
        check_int("b2b_done_count", done_cnt - d0, 2);

        // Mid-word reset at bit 20.
        d0   = done_cnt;
        din  = 34'h2_5A5A_5A5A;
        load = 1'b1;
        for (int k = 0; k <= 20; k++) begin
            exp_q.push_back({din[k], 1'b0});
        end
        step();
        load = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mrst_valid", dout_valid, 1'b0);
            check("mrst_ready", ready, 1'b1);
            check("mrst_done", done, 1'b0);
            step();
        end
        check_int("mrst_done_count", done_cnt - d0, 0);
        run_word(34'h1, -1, 0, -1);

        check_int("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
